display_scan_mux: RTL and testbench

- Time-multiplexed 4-digit scanner for the alarm-clock display.
- Takes four packed BCD digits (HH:MM) from the timekeeping/alarm-set logic.
- Cycles one digit at a time onto the shared `number_out` bus, which drives the 7-segment decoder's 4-bit `number` input.
- Also generates active-low anode enables, a colon/decimal-point drive, edit-mode blinking and anti-ghosting dead time.

---
 rtl/display_scan_mux.sv | 109 ++++++++++
 tb/tb_display_scan_mux.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed 4-digit scanner for the alarm-clock display.
// Selects one BCD digit at a time onto number_out. It also drives the matching
// active-low anode and the active-low decimal point, and it provides edit-mode
// blinking and a dead time at the start of each slot to stop ghosting.
// Scan order is hours tens (idx 3) down to minutes ones (idx 0). The full
// 16-bit value is latched once per frame so a frame never shows a torn time.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a leading zero in the hours
// tens position.
module display_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        display_en,
  output logic [3:0]  number_out,
  output logic [3:0]  anode,
  output logic        dp,
  output logic [1:0]  digit_idx
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [15:0]   snapshot;

  logic          refresh_wrap;
  logic          blink_wrap;
  logic [3:0]    cur_digit;
  logic          dead_time;
  logic          bad_code;
  logic          lead_zero;
  logic          blank;

  assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign blink_wrap   = (blink_cnt == BW'(BLINK_DIV - 1));

  // Decode the digit under the current slot and decide whether it is blanked.
  always_comb begin
    cur_digit = snapshot[{idx, 2'b00} +: 4];
    dead_time = (refresh_cnt < RW'(DEAD_CYCLES));
    bad_code  = (cur_digit > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = (idx == 2'd3) && (cur_digit == 4'd0);
`else
    lead_zero = 1'b0;
`endif
    blank = dead_time | ~display_en | (blink_mask[idx] & blink_phase) |
            bad_code | lead_zero;
  end

  // Slot timing: the refresh counter sets the slot length and idx steps down
  // once per slot. The 0->3 step marks the frame boundary where the digits are
  // latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      snapshot    <= 16'h0000;
    end else begin
      if (refresh_wrap) begin
        refresh_cnt <= '0;
        idx         <= idx - 2'd1;
        if (idx == 2'd0) begin
          snapshot <= digits_in;
        end
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
    end
  end

  // Free-running blink timebase. It keeps running whatever display_en does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Registered outputs. They trail the slot state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      number_out <= 4'd0;
      anode      <= 4'b1111;
      dp         <= 1'b1;
      digit_idx  <= 2'd0;
    end else begin
      digit_idx  <= idx;
      number_out <= bad_code ? 4'd0 : cur_digit;
      anode      <= blank ? 4'b1111 : ~(4'b0001 << idx);
      dp         <= blank ? 1'b1 : ~dp_mask[idx];
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux. The reference model derives the expected outputs
// from the elapsed clock count since reset using plain arithmetic. It also keeps
// the value latched at each frame boundary.
module tb_display_scan_mux;

  localparam int R  = 4;
  localparam int B  = 32;
  localparam int DC = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic        display_en;
  logic [3:0]  number_out;
  logic [3:0]  anode;
  logic        dp;
  logic [1:0]  digit_idx;

  int          n_assert = 0;
  int          n_fail = 0;
  int          t = 0;
  logic [15:0] snap_m = 16'h0000;

  display_scan_mux #(
    .REFRESH_DIV(R),
    .BLINK_DIV(B),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .digits_in(digits_in),
    .blink_mask(blink_mask),
    .dp_mask(dp_mask),
    .display_en(display_en),
    .number_out(number_out),
    .anode(anode),
    .dp(dp),
    .digit_idx(digit_idx)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_number_out"}, number_out, 4'd0);
    check({tag, "_anode"}, anode, 4'b1111);
    check({tag, "_dp"}, {3'b000, dp}, 4'd0 | 4'd1);
    check({tag, "_digit_idx"}, {2'b00, digit_idx}, 4'd0);
  endtask

  // One clock: predict the outputs from the model, advance, then compare.
  task automatic tick();
    int   rc, slot, idx, ph, d;
    bit   blank;
    logic [3:0] e_num, e_an;
    logic e_dp;
    rc   = t % R;
    slot = t / R;
    idx  = (4 - (slot % 4)) % 4;
    ph   = (t / B) % 2;
    d    = int'((snap_m >> (4 * idx)) & 16'h000F);
    blank = (rc < DC) || !display_en || (blink_mask[idx] && ph == 1) || (d > 9);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 3 && d == 0) blank = 1'b1;
`endif
    e_num = (d > 9) ? 4'd0 : 4'(d);
    e_an  = blank ? 4'b1111 : ~(4'b0001 << idx);
    e_dp  = blank ? 1'b1 : ~dp_mask[idx];
    if (rc == R - 1 && idx == 0) snap_m = digits_in;
    @(posedge clk);
    #1;
    t++;
    check("number_out", number_out, e_num);
    check("anode", anode, e_an);
    check("dp", {3'b000, dp}, {3'b000, e_dp});
    check("digit_idx", {2'b00, digit_idx}, 4'(idx));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset      = 1'b1;
    digits_in  = 16'h0000;
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
    display_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("reset");
    reset  = 1'b0;
    t      = 0;
    snap_m = 16'h0000;

    // First frame shows 0000, then 1234 from the first boundary onward.
    digits_in = 16'h1234;
    run(42);

    // Mid-frame change: takes effect at the next boundary only.
    digits_in = 16'h0959;
    run(40);

    // Hours digits blink across both blink phases.
    digits_in  = 16'h1234;
    blink_mask = 4'b1100;
    run(140);
    blink_mask = 4'b0000;

    // Non-BCD code in minutes tens.
    digits_in = 16'h12B4;
    run(36);

    // Decimal point on digit 2, then the display is disabled and re-enabled.
    digits_in = 16'h1234;
    dp_mask   = 4'b0100;
    run(36);
    display_en = 1'b0;
    run(34);
    display_en = 1'b1;
    run(20);
    dp_mask = 4'b0000;

    // Leading zero in hours tens.
    digits_in = 16'h0745;
    run(40);

    // Randomised stretch.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 23) == 0) display_en = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset asserted mid-slot: outputs clear without waiting for a clock.
    digits_in  = 16'h1234;
    display_en = 1'b1;
    blink_mask = 4'b0000;
    run(6);
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    check_reset_values("held_reset");
    reset  = 1'b0;
    t      = 0;
    snap_m = 16'h0000;
    digits_in = 16'h0852;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
